// File: rtl/drp_arbiter.sv
// drp_arbiter: serializes two requesters (A = QPLL sequencer, B = register bank) onto one DRP port.
// Define DRP_ARB_TIMEOUT_EN to compile in DRP_RDY timeout recovery (parameter TIMEOUT, 2..255).
module drp_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        DRP_CLK,
    input  logic        DRP_RST,
    input  logic        a_en,
    input  logic        a_we,
    input  logic [7:0]  a_addr,
    input  logic [15:0] a_di,
    output logic [15:0] a_do,
    output logic        a_rdy,
    output logic        a_err,
    input  logic        b_en,
    input  logic        b_we,
    input  logic [7:0]  b_addr,
    input  logic [15:0] b_di,
    output logic [15:0] b_do,
    output logic        b_rdy,
    output logic        b_err,
    output logic [7:0]  DRP_ADDR,
    output logic [15:0] DRP_DI,
    output logic        DRP_EN,
    output logic        DRP_WE,
    input  logic [15:0] DRP_DO,
    input  logic        DRP_RDY,
    output logic        busy,
    output logic        owner,
    output logic [7:0]  tmo_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic        pend_a, pend_b;
    logic        a_we_q, b_we_q;
    logic [7:0]  a_addr_q, b_addr_q;
    logic [15:0] a_di_q, b_di_q;
    logic        drp_we_q;
    logic [15:0] rdata_q;
    logic        err_q;
    logic        grant_b, take_a, take_b, finish, timeout;

    // On contention the port that did not own the last grant wins.
    assign grant_b = pend_b && (!pend_a || !owner);
    // A request is dropped while its port is pending or its own transaction is still in flight.
    assign take_a  = a_en && !pend_a && !(busy && !owner);
    assign take_b  = b_en && !pend_b && !(busy && owner);
    assign finish  = (state == WAIT) && (DRP_RDY || timeout);

`ifdef DRP_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic [7:0] tmo_q;

    assign timeout = (state == WAIT) && !DRP_RDY && (wait_cnt == 8'(TIMEOUT - 1));
    assign tmo_cnt = tmo_q;

    always_ff @(posedge DRP_CLK) begin
        if (DRP_RST) begin
            wait_cnt <= 8'h00;
            tmo_q    <= 8'h00;
        end else begin
            if (state == ISSUE)
                wait_cnt <= 8'h00;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + 8'h01;
            if (timeout && tmo_q != 8'hFF)
                tmo_q <= tmo_q + 8'h01;
        end
    end
`else
    assign timeout = 1'b0;
    assign tmo_cnt = 8'h00;
`endif

    always_comb begin
        // NOTE: next state defaults to the current one first so no path leaves it unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (pend_a || pend_b) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (finish) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: request payload is qualified by the pending bits, so these registers carry no reset.
    always_ff @(posedge DRP_CLK) begin
        if (take_a) begin
            a_we_q   <= a_we;
            a_addr_q <= a_addr;
            a_di_q   <= a_di;
        end
        if (take_b) begin
            b_we_q   <= b_we;
            b_addr_q <= b_addr;
            b_di_q   <= b_di;
        end
    end

    // NOTE: all state updates use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge DRP_CLK) begin
        if (DRP_RST) begin
            state    <= IDLE;
            pend_a   <= 1'b0;
            pend_b   <= 1'b0;
            owner    <= 1'b1;
            DRP_ADDR <= 8'h00;
            DRP_DI   <= 16'h0000;
            drp_we_q <= 1'b0;
            rdata_q  <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take_a) pend_a <= 1'b1;
            if (take_b) pend_b <= 1'b1;
            if (state == IDLE && (pend_a || pend_b)) begin
                owner    <= grant_b;
                DRP_ADDR <= grant_b ? b_addr_q : a_addr_q;
                DRP_DI   <= grant_b ? b_di_q   : a_di_q;
                drp_we_q <= grant_b ? b_we_q   : a_we_q;
            end
            if (finish) begin
                rdata_q <= DRP_RDY ? DRP_DO : 16'h0000;
                err_q   <= !DRP_RDY;
                if (owner) pend_b <= 1'b0;
                else       pend_a <= 1'b0;
            end
        end
    end

    assign busy   = (state != IDLE);
    assign DRP_EN = (state == ISSUE);
    assign DRP_WE = drp_we_q && DRP_EN;
    assign a_rdy  = (state == DONE) && !owner;
    assign b_rdy  = (state == DONE) && owner;
    assign a_do   = a_rdy ? rdata_q : 16'h0000;
    assign b_do   = b_rdy ? rdata_q : 16'h0000;
    assign a_err  = a_rdy && err_q;
    assign b_err  = b_rdy && err_q;

endmodule

// File: tb/tb_drp_arbiter.sv
// tb_drp_arbiter: table-driven cycle vectors plus hand sequences for drp_arbiter.
// Timeout expectations switch on DRP_ARB_TIMEOUT_EN (TIMEOUT = 8 in that build).
module tb_drp_arbiter;

    logic        DRP_CLK = 1'b0;
    logic        DRP_RST;
    logic        a_en, a_we, b_en, b_we;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_di, b_di;
    logic [15:0] a_do, b_do;
    logic        a_rdy, a_err, b_rdy, b_err;
    logic [7:0]  DRP_ADDR;
    logic [15:0] DRP_DI;
    logic        DRP_EN, DRP_WE;
    logic [15:0] DRP_DO;
    logic        DRP_RDY;
    logic        busy, owner;
    logic [7:0]  tmo_cnt;

    int total = 0;
    int bad   = 0;

    always #5 DRP_CLK = ~DRP_CLK;

    drp_arbiter #(.TIMEOUT(8)) dut (
        .DRP_CLK(DRP_CLK), .DRP_RST(DRP_RST),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_di(a_di),
        .a_do(a_do), .a_rdy(a_rdy), .a_err(a_err),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_di(b_di),
        .b_do(b_do), .b_rdy(b_rdy), .b_err(b_err),
        .DRP_ADDR(DRP_ADDR), .DRP_DI(DRP_DI), .DRP_EN(DRP_EN), .DRP_WE(DRP_WE),
        .DRP_DO(DRP_DO), .DRP_RDY(DRP_RDY),
        .busy(busy), .owner(owner), .tmo_cnt(tmo_cnt)
    );

    typedef struct packed {
        logic        rst;
        logic        a_en;
        logic        a_we;
        logic [7:0]  a_addr;
        logic [15:0] a_di;
        logic        b_en;
        logic        b_we;
        logic [7:0]  b_addr;
        logic [15:0] b_di;
        logic        rdy;
        logic [15:0] rdo;
    } ins_t;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] di;
        logic        busy;
        logic        owner;
        logic        a_rdy;
        logic [15:0] a_do;
        logic        a_err;
        logic        b_rdy;
        logic [15:0] b_do;
        logic        b_err;
        logic [7:0]  tmo;
    } outs_t;

    typedef struct {
        ins_t  i;
        outs_t o;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge DRP_CLK);
        #1;
    endtask

    function automatic ins_t mk_in(bit rst, bit ae, bit awe, logic [7:0] aad, logic [15:0] adi,
                                   bit be, bit bwe, logic [7:0] bad_, logic [15:0] bdi,
                                   bit rdy, logic [15:0] rdo);
        ins_t i;
        i = '{rst, ae, awe, aad, adi, be, bwe, bad_, bdi, rdy, rdo};
        return i;
    endfunction

    function automatic outs_t mk_out(bit en, bit we, logic [7:0] addr, logic [15:0] di, bit bsy,
                                     bit own, bit ardy, logic [15:0] ado, bit brdy, logic [15:0] bdo);
        outs_t o;
        o = '{en, we, addr, di, bsy, own, ardy, ado, 1'b0, brdy, bdo, 1'b0, 8'h00};
        return o;
    endfunction

    function automatic outs_t z_outs();
        outs_t o;
        o = '0;
        o.owner = 1'b1;
        return o;
    endfunction

    function automatic outs_t get_outs();
        outs_t o;
        o = '{DRP_EN, DRP_WE, DRP_ADDR, DRP_DI, busy, owner, a_rdy, a_do, a_err,
              b_rdy, b_do, b_err, tmo_cnt};
        return o;
    endfunction

    task automatic apply_in(input ins_t i);
        DRP_RST = i.rst;
        a_en = i.a_en; a_we = i.a_we; a_addr = i.a_addr; a_di = i.a_di;
        b_en = i.b_en; b_we = i.b_we; b_addr = i.b_addr; b_di = i.b_di;
        DRP_RDY = i.rdy; DRP_DO = i.rdo;
    endtask

    task automatic do_reset();
        apply_in(mk_in(1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0, 16'h0));
        step();
        step();
        DRP_RST = 1'b0;
    endtask

    // Both ports kept busy for three rounds; DRP model answers two cycles after each EN.
    task automatic seq_contention();
        int  na, nb, ndone, nen, cd;
        bit  pa, pb, outstanding, last_b;
        logic [15:0] exp_data;
        na = 0; nb = 0; ndone = 0; nen = 0; cd = 0;
        pa = 1; pb = 1; outstanding = 0; last_b = 0; exp_data = '0;
        do_reset();
        for (int cyc = 0; cyc < 300 && ndone < 6; cyc++) begin
            a_en = pa; b_en = pb; a_we = 0; b_we = 0;
            if (pa) begin a_addr = 8'(8'hA0 + na); na++; end
            if (pb) begin b_addr = 8'(8'hB0 + nb); nb++; end
            pa = 0; pb = 0;
            DRP_RDY = 0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin DRP_RDY = 1; DRP_DO = exp_data; end
            end
            if (DRP_EN) begin
                check("grant", {outstanding, owner, DRP_ADDR[7:4]},
                      {1'b0, nen[0], (nen[0] ? 4'hB : 4'hA)});
                outstanding = 1; last_b = owner; cd = 2;
                exp_data = {DRP_ADDR, DRP_ADDR};
                nen++;
            end
            if (a_rdy || b_rdy) begin
                check("rr_rdy", {a_rdy, b_rdy, a_do | b_do}, {!last_b, last_b, exp_data});
                outstanding = 0; ndone++;
                if (a_rdy && na < 3) pa = 1;
                if (b_rdy && nb < 3) pb = 1;
            end
            step();
        end
        a_en = 0; b_en = 0; DRP_RDY = 0;
        check("rr_counts", {8'(nen), 8'(ndone)}, {8'd6, 8'd6});
    endtask

    // b_en re-pulsed with another address while B is in WAIT.
    task automatic seq_repulse();
        int nen, na_rdy, nb_rdy;
        logic [7:0]  addr_seen;
        logic [15:0] do_seen;
        nen = 0; na_rdy = 0; nb_rdy = 0; addr_seen = '0; do_seen = '0;
        do_reset();
        for (int cyc = 0; cyc < 16; cyc++) begin
            b_en = 0; DRP_RDY = 0;
            if (cyc == 0) begin b_en = 1; b_we = 0; b_addr = 8'h44; b_di = 16'h0; end
            if (cyc == 3) begin b_en = 1; b_we = 1; b_addr = 8'h55; b_di = 16'hCCCC; end
            if (cyc == 5) begin DRP_RDY = 1; DRP_DO = 16'h1111; end
            if (DRP_EN) begin nen++; addr_seen = DRP_ADDR; end
            if (a_rdy) na_rdy++;
            if (b_rdy) begin nb_rdy++; do_seen = b_do; end
            step();
        end
        check("repulse_en_count", 32'(nen), 32'd1);
        check("repulse_addr", addr_seen, 8'h44);
        check("repulse_rdy_count", {8'(na_rdy), 8'(nb_rdy)}, {8'd0, 8'd1});
        check("repulse_do", do_seen, 16'h1111);
    endtask

    // Reset lands during WAIT; a late DRP_RDY must not complete anything.
    task automatic seq_reset_wait();
        int  stray;
        bit  seen;
        stray = 0; seen = 0;
        do_reset();
        a_en = 1; a_we = 0; a_addr = 8'h77; a_di = 16'h0;
        step();
        a_en = 0;
        step();
        check("rst_issue", {DRP_EN, DRP_ADDR}, {1'b1, 8'h77});
        step();
        DRP_RST = 1;
        check("rst_in_wait", busy, 1'b1);
        step();
        DRP_RST = 0;
        check("rst_outputs", get_outs(), z_outs());
        DRP_RDY = 1; DRP_DO = 16'h9999;
        step();
        DRP_RDY = 0;
        for (int k = 0; k < 3; k++) begin
            if (busy || a_rdy || b_rdy) stray++;
            step();
        end
        check("rst_late_rdy", 32'(stray), 32'd0);
        a_en = 1; a_addr = 8'h78;
        step();
        a_en = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            DRP_RDY = 0;
            if (DRP_EN) begin
                step();
                DRP_RDY = 1; DRP_DO = 16'h7878;
            end
            if (a_rdy) begin
                seen = 1;
                check("rst_recover", {a_do, a_err, b_rdy}, {16'h7878, 1'b0, 1'b0});
            end
            step();
        end
        DRP_RDY = 0;
        check("rst_recover_seen", seen, 1'b1);
    endtask

    // B read where the DRP never answers in time.
    task automatic seq_timeout();
        do_reset();
        b_en = 1; b_we = 0; b_addr = 8'h99; b_di = 16'h0;
        step();
        b_en = 0;
        repeat (10) step();
`ifdef DRP_ARB_TIMEOUT_EN
        check("tmo_done", {b_rdy, b_err, b_do, a_rdy}, {1'b1, 1'b1, 16'h0000, 1'b0});
        step();
        DRP_RDY = 1; DRP_DO = 16'hBEEF;
        check("tmo_cnt", {busy, tmo_cnt}, {1'b0, 8'd1});
        step();
        DRP_RDY = 0;
        check("tmo_late_rdy", {busy, a_rdy, b_rdy, tmo_cnt}, {1'b0, 1'b0, 1'b0, 8'd1});
`else
        check("no_tmo_wait", {busy, b_rdy}, {1'b1, 1'b0});
        DRP_RDY = 1; DRP_DO = 16'hBEEF;
        step();
        DRP_RDY = 0;
        check("slow_rdy", {b_rdy, b_err, b_do, tmo_cnt}, {1'b1, 1'b0, 16'hBEEF, 8'h00});
`endif
    endtask

    initial begin
        outs_t z;
        ins_t  n;
        z = z_outs();
        n = mk_in(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0, 16'h0);

        // Single A read, then simultaneous A write / B read, then RDY in IDLE.
        vt.push_back('{mk_in(0, 1, 0, 8'h36, 16'h7777, 0, 0, 8'h00, 16'h0, 0, 16'h0), z});
        vt.push_back('{n, z});
        vt.push_back('{n, mk_out(1, 0, 8'h36, 16'h7777, 1, 0, 0, 16'h0, 0, 16'h0)});
        vt.push_back('{n, mk_out(0, 0, 8'h36, 16'h7777, 1, 0, 0, 16'h0, 0, 16'h0)});
        vt.push_back('{n, mk_out(0, 0, 8'h36, 16'h7777, 1, 0, 0, 16'h0, 0, 16'h0)});
        vt.push_back('{mk_in(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 1, 16'hA5C3),
                       mk_out(0, 0, 8'h36, 16'h7777, 1, 0, 0, 16'h0, 0, 16'h0)});
        vt.push_back('{n, mk_out(0, 0, 8'h36, 16'h7777, 1, 0, 1, 16'hA5C3, 0, 16'h0)});
        vt.push_back('{mk_in(1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0, 16'h0),
                       mk_out(0, 0, 8'h36, 16'h7777, 0, 0, 0, 16'h0, 0, 16'h0)});
        vt.push_back('{mk_in(0, 1, 1, 8'h10, 16'h1234, 1, 0, 8'h20, 16'h0000, 0, 16'h0), z});
        vt.push_back('{n, z});
        vt.push_back('{n, mk_out(1, 1, 8'h10, 16'h1234, 1, 0, 0, 16'h0, 0, 16'h0)});
        vt.push_back('{mk_in(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 1, 16'hDEAD),
                       mk_out(0, 0, 8'h10, 16'h1234, 1, 0, 0, 16'h0, 0, 16'h0)});
        vt.push_back('{n, mk_out(0, 0, 8'h10, 16'h1234, 1, 0, 1, 16'hDEAD, 0, 16'h0)});
        vt.push_back('{n, mk_out(0, 0, 8'h10, 16'h1234, 0, 0, 0, 16'h0, 0, 16'h0)});
        vt.push_back('{n, mk_out(1, 0, 8'h20, 16'h0000, 1, 1, 0, 16'h0, 0, 16'h0)});
        vt.push_back('{mk_in(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 1, 16'h5A5A),
                       mk_out(0, 0, 8'h20, 16'h0000, 1, 1, 0, 16'h0, 0, 16'h0)});
        vt.push_back('{n, mk_out(0, 0, 8'h20, 16'h0000, 1, 1, 0, 16'h0, 1, 16'h5A5A)});
        vt.push_back('{mk_in(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 1, 16'hFFFF),
                       mk_out(0, 0, 8'h20, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0)});
        vt.push_back('{n, mk_out(0, 0, 8'h20, 16'h0000, 0, 1, 0, 16'h0, 0, 16'h0)});

        do_reset();
        check("reset_state", get_outs(), z);

        for (int k = 0; k < vt.size(); k++) begin
            apply_in(vt[k].i);
            check($sformatf("vec%0d", k), get_outs(), vt[k].o);
            step();
        end
        apply_in(n);

        seq_contention();
        seq_repulse();
        seq_reset_wait();
        seq_timeout();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
